fish_calib_sel: RTL and testbench
=================================

// Module: fish_calib_sel
// PURPOSE
//  Parametrised calibration-step selector for the fish counter. N_CASES priority-encoded case
//  inputs pick one entry of a run-time writable calibration table. Each new selection must be
//  held stable through a debounce window before it is committed. Drives the fish_cal threshold
//  consumed by the counting logic, plus the committed index and a one-cycle change strobe.
// PARAMETERS
//  N_CASES     3                       number of case inputs / table entries (>=2)
//  W           4                       width of each calibration value
//  DEB_CYCLES  4                       consecutive samples required to commit a selection (>=1)
//  DEFAULT_IDX 0                       entry used when no case input is high (<N_CASES)
//  INIT_TABLE  {4'd15,4'd10,4'd5}      packed reset values; entry i = INIT_TABLE[i*W +: W]
// PORTS
//  clk         in   1              system clock, all logic on rising edge
//  reset       in   1              synchronous, active-high reset
//  case_in     in   N_CASES        case request lines; bit 0 = highest priority
//  wr_en       in   1              table write strobe
//  wr_idx      in   IW             table entry to write, IW = max(1,$clog2(N_CASES))
//  wr_data     in   W              value written to table[wr_idx]
//  fish_cal    out  W              registered calibration value = table[cal_idx]
//  cal_idx     out  IW             committed selection index
//  cal_change  out  1              1-cycle pulse on the edge a new index is committed
// BEHAVIOUR
//  Reset (clk edge with reset=1): table[i] <= INIT_TABLE entry i; cal_idx <= DEFAULT_IDX;
//   fish_cal <= INIT entry DEFAULT_IDX; cal_change <= 0; pending <= DEFAULT_IDX; deb_cnt <= 0.
//   Reset overrides wr_en and all other activity in the same cycle. Reset asserted mid-debounce
//   discards the pending request.
//  Request: req = index of lowest set bit of case_in; req = DEFAULT_IDX when case_in == 0.
//  Debounce, per edge (reset=0):
//   - req != pending: pending <= req; deb_cnt <= 1; commit here only if DEB_CYCLES == 1.
//   - req == pending, deb_cnt < DEB_CYCLES: deb_cnt <= deb_cnt+1.
//   - Commit: fires on the edge where deb_cnt+1 == DEB_CYCLES, or on the first sample when
//     DEB_CYCLES == 1. The request has then been sampled on DEB_CYCLES consecutive edges.
//     deb_cnt saturates at DEB_CYCLES.
//   - On commit with pending != cal_idx: cal_idx <= pending and cal_change <= 1.
//     Otherwise cal_change <= 0.
//   - A commit that selects the index already in cal_idx produces no pulse.
//   - Any glitch shorter than DEB_CYCLES edges leaves cal_idx unchanged.
//  Latency: DEB_CYCLES=1 gives a 1-cycle case_in->fish_cal response (legacy behaviour).
//   In general fish_cal updates on the same edge as cal_idx.
//  Table write (wr_en=1, reset=0): table[wr_idx] <= wr_data.
//   - wr_idx >= N_CASES is ignored silently.
//   - Write-through: fish_cal <= wr_data on that edge when wr_idx matches the index being
//     presented next cycle (new cal_idx on a commit edge, else current cal_idx).
//   - A write to a non-selected entry does not change fish_cal.
//   - Writes do not affect debounce state or cal_change.
//  fish_cal otherwise <= table[next cal_idx] every edge. It is never combinational from inputs.
//  Arithmetic: deb_cnt width = $clog2(DEB_CYCLES+1). No wrap-around is possible (saturating).
// TESTING
//  1 Reset, defaults: after reset, case_in=0 -> fish_cal=5, cal_idx=0, cal_change=0 on every
//    cycle.
//  2 Priority: case_in=3'b110 held 4 edges -> cal_idx=1, fish_cal=10, single cal_change pulse
//    on edge 4. Then case_in=3'b111 held 4 edges -> cal_idx=0, fish_cal=5.
//  3 Debounce: case_in=3'b100 for 3 edges, then 0 -> no change. Held 4 edges -> fish_cal=15
//    exactly on the 4th edge. DEB_CYCLES=1 build -> 1-cycle response.
//  4 Table write: selected idx 2, wr_en wr_idx=2 wr_data=9 -> fish_cal=9 next cycle.
//    wr_idx=1 wr_data=7 -> fish_cal stays 9. wr_idx=3 -> table unchanged.
//  5 Simultaneous: commit to idx1 on the same edge as a write of 12 to idx1 -> fish_cal=12,
//    cal_change=1.
//  6 Reset mid-debounce after 2 edges of case_in=3'b010 -> cal_idx=0. Counting restarts;
//    4 more edges are needed to commit.

Source files
------------

// File: rtl/fish_calib_sel.sv
// Calibration-step selector: priority-encoded case inputs choose a table entry, which is
// debounced before being committed and presented as the registered fish_cal threshold.
module fish_calib_sel #(
    parameter int                     N_CASES     = 3,
    parameter int                     W           = 4,
    parameter int                     DEB_CYCLES  = 4,
    parameter int                     DEFAULT_IDX = 0,
    parameter logic [N_CASES*W-1:0]   INIT_TABLE  = {4'd15, 4'd10, 4'd5},
    localparam int                    IW          = (N_CASES > 1) ? $clog2(N_CASES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CASES-1:0] case_in,
    input  logic               wr_en,
    input  logic [IW-1:0]      wr_idx,
    input  logic [W-1:0]       wr_data,
    output logic [W-1:0]       fish_cal,
    output logic [IW-1:0]      cal_idx,
    output logic               cal_change
);

    localparam int               CW      = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]    DEB_C   = CW'(DEB_CYCLES);
    localparam logic [IW-1:0]    DEF_IDX = IW'(DEFAULT_IDX);
    localparam logic [IW:0]      NC      = (IW + 1)'(N_CASES);

    logic [W-1:0]  table_q [N_CASES];
    logic [IW-1:0] pending_q, pending_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [IW-1:0] cal_idx_q, cal_idx_d;
    logic [W-1:0]  fish_cal_q, fish_cal_d;
    logic          cal_change_q, cal_change_d;

    logic [IW-1:0] req;
    logic          commit;
    logic          wr_hit;

    // Lowest set bit wins; scanning downwards lets the lowest index overwrite.
    always_comb begin
        req = DEF_IDX;
        for (int i = N_CASES - 1; i >= 0; i--) begin
            if (case_in[i]) begin
                req = IW'(i);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        deb_cnt_d = deb_cnt_q;
        commit    = 1'b0;
        if (req != pending_q) begin
            pending_d = req;
            deb_cnt_d = CW'(1);
            commit    = (DEB_CYCLES == 1);
        end else if (deb_cnt_q < DEB_C) begin
            deb_cnt_d = deb_cnt_q + CW'(1);
            commit    = (deb_cnt_d == DEB_C);
        end
    end

    always_comb begin
        cal_change_d = commit && (pending_d != cal_idx_q);
        cal_idx_d    = cal_change_d ? pending_d : cal_idx_q;
        wr_hit       = wr_en && ({1'b0, wr_idx} < NC);
        // Write-through keeps fish_cal coherent with a same-edge table update.
        if (wr_hit && (wr_idx == cal_idx_d)) begin
            fish_cal_d = wr_data;
        end else begin
            fish_cal_d = table_q[cal_idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CASES; i++) begin
                table_q[i] <= INIT_TABLE[i*W +: W];
            end
            pending_q    <= DEF_IDX;
            deb_cnt_q    <= '0;
            cal_idx_q    <= DEF_IDX;
            fish_cal_q   <= INIT_TABLE[DEFAULT_IDX*W +: W];
            cal_change_q <= 1'b0;
        end else begin
            if (wr_hit) begin
                table_q[wr_idx] <= wr_data;
            end
            pending_q    <= pending_d;
            deb_cnt_q    <= deb_cnt_d;
            cal_idx_q    <= cal_idx_d;
            fish_cal_q   <= fish_cal_d;
            cal_change_q <= cal_change_d;
        end
    end

    assign fish_cal   = fish_cal_q;
    assign cal_idx    = cal_idx_q;
    assign cal_change = cal_change_q;

endmodule

// File: tb/tb_fish_calib_sel.sv
// Directed bench for fish_calib_sel: default build (DEB_CYCLES=4) plus a DEB_CYCLES=1 build.
module tb_fish_calib_sel;

    logic       clk;
    logic       reset;
    logic [2:0] case_in, case_in1;
    logic       wr_en, wr_en1;
    logic [1:0] wr_idx, wr_idx1;
    logic [3:0] wr_data, wr_data1;
    logic [3:0] fish_cal, fish_cal1;
    logic [1:0] cal_idx, cal_idx1;
    logic       cal_change, cal_change1;

    int checks = 0;
    int errors = 0;

    fish_calib_sel dut (
        .clk(clk), .reset(reset), .case_in(case_in), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .fish_cal(fish_cal), .cal_idx(cal_idx), .cal_change(cal_change)
    );

    fish_calib_sel #(.DEB_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .case_in(case_in1), .wr_en(wr_en1), .wr_idx(wr_idx1),
        .wr_data(wr_data1), .fish_cal(fish_cal1), .cal_idx(cal_idx1), .cal_change(cal_change1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({fish_cal, cal_idx, cal_change} !== {4'd5, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got fish=%0d idx=%0d chg=%0d, want 5 0 0", fish_cal, cal_idx, cal_change);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({fish_cal, cal_idx, cal_change} !== {4'd5, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL idle_default[%0d]: got fish=%0d idx=%0d chg=%0d, want 5 0 0", i, fish_cal, cal_idx, cal_change);
            end
        end
    endtask

    task automatic test_priority();
        case_in = 3'b110;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (i < 4) begin
                if ({fish_cal, cal_idx, cal_change} !== {4'd5, 2'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL prio_110_wait[%0d]: got fish=%0d idx=%0d chg=%0d, want 5 0 0", i, fish_cal, cal_idx, cal_change);
                end
            end else if (i == 4) begin
                if ({fish_cal, cal_idx, cal_change} !== {4'd10, 2'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL prio_110_commit: got fish=%0d idx=%0d chg=%0d, want 10 1 1", fish_cal, cal_idx, cal_change);
                end
            end else begin
                if ({fish_cal, cal_idx, cal_change} !== {4'd10, 2'd1, 1'b0}) begin
                    errors++;
                    $display("FAIL prio_110_hold: got fish=%0d idx=%0d chg=%0d, want 10 1 0", fish_cal, cal_idx, cal_change);
                end
            end
        end
        case_in = 3'b111;
        for (int i = 1; i <= 4; i++) step();
        checks++;
        if ({fish_cal, cal_idx, cal_change} !== {4'd5, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL prio_111_commit: got fish=%0d idx=%0d chg=%0d, want 5 0 1", fish_cal, cal_idx, cal_change);
        end
    endtask

    task automatic test_debounce();
        case_in = 3'b100;
        for (int i = 0; i < 3; i++) step();
        case_in = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({fish_cal, cal_idx, cal_change} !== {4'd5, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL glitch_ignored[%0d]: got fish=%0d idx=%0d chg=%0d, want 5 0 0", i, fish_cal, cal_idx, cal_change);
            end
        end
        case_in = 3'b100;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if ({fish_cal, cal_idx} !== {4'd5, 2'd0}) begin
            errors++;
            $display("FAIL deb_edge3: got fish=%0d idx=%0d, want 5 0", fish_cal, cal_idx);
        end
        step();
        checks++;
        if ({fish_cal, cal_idx, cal_change} !== {4'd15, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL deb_edge4: got fish=%0d idx=%0d chg=%0d, want 15 2 1", fish_cal, cal_idx, cal_change);
        end
    endtask

    task automatic test_deb1();
        case_in1 = 3'b010;
        step();
        checks++;
        if ({fish_cal1, cal_idx1, cal_change1} !== {4'd10, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL deb1_fast: got fish=%0d idx=%0d chg=%0d, want 10 1 1", fish_cal1, cal_idx1, cal_change1);
        end
        step();
        checks++;
        if ({fish_cal1, cal_idx1, cal_change1} !== {4'd10, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL deb1_hold: got fish=%0d idx=%0d chg=%0d, want 10 1 0", fish_cal1, cal_idx1, cal_change1);
        end
        case_in1 = 3'b001;
        step();
        checks++;
        if ({fish_cal1, cal_idx1, cal_change1} !== {4'd5, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL deb1_back: got fish=%0d idx=%0d chg=%0d, want 5 0 1", fish_cal1, cal_idx1, cal_change1);
        end
    endtask

    task automatic test_table_write();
        // idx 2 selected on entry
        wr_en = 1'b1; wr_idx = 2'd2; wr_data = 4'd9;
        step();
        checks++;
        if ({fish_cal, cal_idx, cal_change} !== {4'd9, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL wr_selected: got fish=%0d idx=%0d chg=%0d, want 9 2 0", fish_cal, cal_idx, cal_change);
        end
        wr_idx = 2'd1; wr_data = 4'd7;
        step();
        checks++;
        if (fish_cal !== 4'd9) begin
            errors++;
            $display("FAIL wr_other: got fish=%0d, want 9", fish_cal);
        end
        wr_idx = 2'd3; wr_data = 4'd1;
        step();
        checks++;
        if (fish_cal !== 4'd9) begin
            errors++;
            $display("FAIL wr_oob: got fish=%0d, want 9", fish_cal);
        end
        wr_en = 1'b0;
        case_in = 3'b001;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({fish_cal, cal_idx} !== {4'd5, 2'd0}) begin
            errors++;
            $display("FAIL entry0_intact: got fish=%0d idx=%0d, want 5 0", fish_cal, cal_idx);
        end
        case_in = 3'b010;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({fish_cal, cal_idx} !== {4'd7, 2'd1}) begin
            errors++;
            $display("FAIL entry1_written: got fish=%0d idx=%0d, want 7 1", fish_cal, cal_idx);
        end
        case_in = 3'b000;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_back_to_back();
        case_in = 3'b010;
        for (int i = 0; i < 3; i++) step();
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 4'd12;
        step();
        wr_en = 1'b0;
        checks++;
        if ({fish_cal, cal_idx, cal_change} !== {4'd12, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL commit_with_write: got fish=%0d idx=%0d chg=%0d, want 12 1 1", fish_cal, cal_idx, cal_change);
        end
    endtask

    task automatic test_reset_mid();
        case_in = 3'b000;
        for (int i = 0; i < 4; i++) step();
        case_in = 3'b010;
        for (int i = 0; i < 2; i++) step();
        reset = 1'b1;
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'd3;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        checks++;
        if ({fish_cal, cal_idx, cal_change} !== {4'd5, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got fish=%0d idx=%0d chg=%0d, want 5 0 0", fish_cal, cal_idx, cal_change);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (i < 4) begin
                if (cal_idx !== 2'd0) begin
                    errors++;
                    $display("FAIL restart_wait[%0d]: got idx=%0d, want 0", i, cal_idx);
                end
            end else if ({fish_cal, cal_idx, cal_change} !== {4'd10, 2'd1, 1'b1}) begin
                errors++;
                $display("FAIL restart_commit: got fish=%0d idx=%0d chg=%0d, want 10 1 1", fish_cal, cal_idx, cal_change);
            end
        end
        case_in = 3'b000;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({fish_cal, cal_idx} !== {4'd5, 2'd0}) begin
            errors++;
            $display("FAIL reset_beats_write: got fish=%0d idx=%0d, want 5 0", fish_cal, cal_idx);
        end
    endtask

    initial begin
        reset = 1'b1;
        case_in = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        case_in1 = '0; wr_en1 = 1'b0; wr_idx1 = '0; wr_data1 = '0;
        step();
        test_reset();
        test_priority();
        test_debounce();
        test_deb1();
        test_table_write();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
